// File: rtl/upsample_axis.sv
// Nearest-neighbour 2x2 upsampler on an AXI-Stream pixel path.
// Each pixel is doubled horizontally; each row is replayed once from a row buffer.
module upsample_axis #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_CORES = 1,
  parameter int MAX_COLS   = 64
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            up_mode,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [DATA_WIDTH*CONV_CORES-1:0] s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH*CONV_CORES-1:0] m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            err_overflow
);

  localparam int BW = DATA_WIDTH * CONV_CORES;
  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int CW = $clog2(MAX_COLS + 1);

  typedef enum logic {FILL, REPLAY} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   col, col_n;
  logic [CW-1:0]   ncols, ncols_n;
  logic [AW-1:0]   rd_ptr, rd_ptr_n;
  logic            dup, dup_n;
  logic            last_r, last_n;
  logic            mode_r, mode_n;
  logic            pt_mid, pt_mid_n;
  logic            err_n;
  logic [BW-1:0]   hold_r, hold_n;
  logic            tvalid_n, tlast_n;
  logic [BW-1:0]   tdata_n;
  logic            we;
  logic [BW-1:0]   row_buf [MAX_COLS];

  logic out_free, accept, boundary, at_end;

  // pt_mid tracks an open pass-through row so a mode change waits for tlast
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign boundary = (state == FILL) && (col == '0) && !dup && !pt_mid;
  assign mode_n   = boundary ? up_mode : mode_r;
  assign s_axis_tready = aresetn && out_free && (state == FILL) && !dup;
  assign accept   = s_axis_tvalid && s_axis_tready;
  assign at_end   = (CW'(rd_ptr) == (ncols - 1'b1));

  // next-state and output-register load logic
  always_comb begin
    state_n  = state;
    col_n    = col;
    ncols_n  = ncols;
    rd_ptr_n = rd_ptr;
    dup_n    = dup;
    last_n   = last_r;
    hold_n   = hold_r;
    pt_mid_n = pt_mid;
    err_n    = err_overflow;
    we       = 1'b0;
    tvalid_n = m_axis_tvalid;
    tdata_n  = m_axis_tdata;
    tlast_n  = m_axis_tlast;
    if (out_free) begin
      tvalid_n = 1'b0;
      unique case (1'b1)
        accept && !mode_n: begin
          tvalid_n = 1'b1;
          tdata_n  = s_axis_tdata;
          tlast_n  = s_axis_tlast;
          pt_mid_n = !s_axis_tlast;
        end
        accept && mode_n: begin
          tvalid_n = 1'b1;
          tdata_n  = s_axis_tdata;
          tlast_n  = 1'b0;
          hold_n   = s_axis_tdata;
          last_n   = s_axis_tlast;
          dup_n    = 1'b1;
          if (col < CW'(MAX_COLS)) begin
            we    = 1'b1;
            col_n = col + 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        (state == FILL) && dup: begin
          tvalid_n = 1'b1;
          tdata_n  = hold_r;
          tlast_n  = last_r;
          dup_n    = 1'b0;
          if (last_r) begin
            state_n  = REPLAY;
            rd_ptr_n = '0;
            ncols_n  = col;
            col_n    = '0;
          end
        end
        state == REPLAY: begin
          tvalid_n = 1'b1;
          tdata_n  = row_buf[rd_ptr];
          tlast_n  = dup && at_end;
          dup_n    = !dup;
          if (dup) begin
            if (at_end) begin
              state_n  = FILL;
              rd_ptr_n = '0;
            end else begin
              rd_ptr_n = rd_ptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= FILL;
      col           <= '0;
      ncols         <= '0;
      rd_ptr        <= '0;
      dup           <= 1'b0;
      last_r        <= 1'b0;
      mode_r        <= 1'b0;
      pt_mid        <= 1'b0;
      hold_r        <= '0;
      err_overflow  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_n;
      col           <= col_n;
      ncols         <= ncols_n;
      rd_ptr        <= rd_ptr_n;
      dup           <= dup_n;
      last_r        <= last_n;
      mode_r        <= mode_n;
      pt_mid        <= pt_mid_n;
      hold_r        <= hold_n;
      err_overflow  <= err_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tlast  <= tlast_n;
    end
  end

  // row buffer write during FILL; read combinationally during REPLAY
  always_ff @(posedge aclk) begin
    if (we) row_buf[col[AW-1:0]] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_upsample_axis.sv
// Scoreboard bench for upsample_axis: row-level reference model feeds an
// expected-beat queue that an independent output monitor drains.
module tb_upsample_axis;

  localparam int DW = 16;
  localparam int CC = 2;
  localparam int MC = 4;
  localparam int BW = DW * CC;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          up_mode = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [BW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [BW-1:0] m_tdata;
  logic          m_tlast;
  logic          err;

  upsample_axis #(
    .DATA_WIDTH(DW), .CONV_CORES(CC), .MAX_COLS(MC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .up_mode(up_mode),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
    .err_overflow(err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;

  logic [BW:0]   exp_q [$];
  logic [BW-1:0] row_q [$];
  int            in_cyc [$];
  int            out_cyc [$];
  bit            mid = 0;
  bit            row_mode = 0;
  bit            exp_err = 0;
  bit            st_prev = 0;
  logic [BW:0]   st_val;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  // downstream ready generator
  always @(posedge aclk) begin
    #1;
    if (rdy_mode == 1) m_tready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) m_tready = (cyc % 3 == 0);
  end

  // reference model: the mode of a row is up_mode at its first beat
  always @(negedge aclk) begin
    if (aresetn && s_tvalid && s_tready) begin
      int n;
      if (!mid) row_mode = up_mode;
      in_cyc.push_back(cyc);
      if (!row_mode) begin
        exp_q.push_back({s_tlast, s_tdata});
      end else begin
        exp_q.push_back({1'b0, s_tdata});
        exp_q.push_back({s_tlast, s_tdata});
        row_q.push_back(s_tdata);
        if (s_tlast) begin
          if (row_q.size() > MC) exp_err = 1;
          n = (row_q.size() > MC) ? MC : row_q.size();
          for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, row_q[i]});
            exp_q.push_back({(i == n - 1), row_q[i]});
          end
          row_q.delete();
        end
      end
      mid = !s_tlast;
    end
  end

  // output monitor: stability under stall, then scoreboard compare
  always @(negedge aclk) begin
    if (!aresetn) begin
      st_prev = 0;
    end else begin
      if (st_prev) begin
        check("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, st_val});
      end
      st_prev = m_tvalid && !m_tready;
      st_val  = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {m_tlast, m_tdata}, '0);
        end else begin
          logic [BW:0] e;
          e = exp_q.pop_front();
          check("out_beat", {m_tlast, m_tdata}, e);
        end
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] d, input bit last);
    int t = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    forever begin
      @(negedge aclk);
      if (s_tready) begin
        @(posedge aclk);
        #1;
        break;
      end
      t++;
      if (t > 300) begin
        check("accept_timeout", t, 0);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_row(input int w, input int gap);
    for (int i = 0; i < w; i++) begin
      send_beat(BW'($urandom), i == w - 1);
      if (gap > 0) repeat ($urandom_range(0, gap)) @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge aclk);
      t++;
    end
    check("drain", exp_q.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ib, ob;
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_err", err, 0);
    check("rst_tready", s_tready, 0);
    #22 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // W=3 upsample at full rate, a second row queued straight behind it
    up_mode = 1'b1;
    ib = in_cyc.size();
    ob = out_cyc.size();
    send_row(3, 0);
    send_beat(BW'($urandom), 1'b1);
    drain();
    check("w3_count", out_cyc.size() - ob, 16);
    check("w3_latency", out_cyc[ob], in_cyc[ib] + 1);
    check("w3_contig", out_cyc[ob + 15] - out_cyc[ob], 15);
    check("replay_no_accept", in_cyc[ib + 3] >= out_cyc[ob + 11], 1);

    // single-pixel row
    ob = out_cyc.size();
    send_row(1, 0);
    drain();
    check("single_count", out_cyc.size() - ob, 4);

    // backpressure pattern
    rdy_mode = 2;
    ob = out_cyc.size();
    send_row(2, 0);
    drain();
    check("bp_count", out_cyc.size() - ob, 8);
    rdy_mode = 0;
    m_tready = 1'b1;

    // pass-through, mode raised mid-row, then upsample row
    up_mode = 1'b0;
    ib = in_cyc.size();
    ob = out_cyc.size();
    send_beat(BW'($urandom), 1'b0);
    send_beat(BW'($urandom), 1'b0);
    up_mode = 1'b1;
    send_beat(BW'($urandom), 1'b0);
    send_beat(BW'($urandom), 1'b1);
    drain();
    check("pt_count", out_cyc.size() - ob, 4);
    check("pt_latency", out_cyc[ob + 3], in_cyc[ib + 3] + 1);
    ob = out_cyc.size();
    send_row(2, 0);
    drain();
    check("switch_count", out_cyc.size() - ob, 8);
    check("no_err_yet", err, exp_err);

    // overflow: 6-beat row with a 4-entry buffer
    ob = out_cyc.size();
    send_row(6, 0);
    drain();
    check("ovf_count", out_cyc.size() - ob, 20);
    check("ovf_err", err, exp_err);
    send_row(2, 0);
    drain();
    check("ovf_sticky", err, exp_err);

    // randomized rows, modes, gaps and backpressure
    rdy_mode = 1;
    for (int r = 0; r < 30; r++) begin
      up_mode = 1'($urandom_range(0, 1));
      send_row($urandom_range(1, 6), 2);
    end
    drain();
    rdy_mode = 0;
    m_tready = 1'b1;
    check("rand_err", err, exp_err);

    // reset in the middle of REPLAY
    up_mode = 1'b1;
    ob = out_cyc.size();
    send_row(3, 0);
    begin
      int t = 0;
      while (out_cyc.size() - ob < 8 && t < 100) begin
        @(negedge aclk);
        t++;
      end
    end
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_tready", s_tready, 0);
    exp_q.delete();
    row_q.delete();
    mid = 0;
    exp_err = 0;
    #20 aresetn = 1'b1;
    ob = out_cyc.size();
    repeat (5) @(posedge aclk);
    #1;
    check("post_rst_idle", out_cyc.size() - ob, 0);
    send_row(2, 0);
    drain();
    check("post_rst_count", out_cyc.size() - ob, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
